// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: host transmit FSM states, protocol timing constants
// and the standard command bytes used by keyboard/mouse drivers.
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SHIFT,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    // Cycles that clock and data are both held low before the clock is released.
    localparam int REQ_HOLD_CYCLES = 4;

    localparam logic [7:0] CMD_ENABLE_REPORTING = 8'hF4;
    localparam logic [7:0] CMD_SET_LEDS         = 8'hED;
    localparam logic [7:0] CMD_RESET            = 8'hFF;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake and frame status between a PS/2 driver and the host transmitter.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       error;

    modport master (
        output tx_data, tx_valid,
        input  tx_ready, busy, done, ack_ok, error
    );

    modport slave (
        input  tx_data, tx_valid,
        output tx_ready, busy, done, ack_ok, error
    );
endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for one raw PS/2 line plus falling-edge detect.
// Registers reset high because an idle open-drain PS/2 line floats high.
module ps2_line_sync (
    input  logic clk,
    input  logic res_n,
    input  logic line_raw,
    output logic level,
    output logic fall
);
    logic meta_q;
    logic level_q;
    logic prev_q;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            meta_q  <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            meta_q  <= line_raw;
            level_q <= meta_q;
            prev_q  <= level_q;
        end
    end

    assign level = level_q;
    assign fall  = prev_q & ~level_q;
endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift out one byte
// with odd parity on device clock edges, then collect the device acknowledge.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ         = 2_000_000,
    parameter int INHIBIT_CYCLES = 200,
    parameter int TIMEOUT_CYCLES = 30_000
) (
    input  logic         clk,
    input  logic         res_n,
    ps2_host_tx_if.slave bus,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe
);
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    // Devices only honour a request after the clock has been inhibited for 100 us.
    if (INHIBIT_CYCLES < CLK_HZ / 10_000) begin : g_inhibit_check
        $error("INHIBIT_CYCLES is shorter than 100 us at CLK_HZ");
    end

    logic clk_level, clk_fall, data_level, data_fall;

    ps2_line_sync u_clk_sync (
        .clk      (clk),
        .res_n    (res_n),
        .line_raw (ps2_clk_in),
        .level    (clk_level),
        .fall     (clk_fall)
    );

    ps2_line_sync u_data_sync (
        .clk      (clk),
        .res_n    (res_n),
        .line_raw (ps2_data_in),
        .level    (data_level),
        .fall     (data_fall)
    );

    ps2_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             parity_q, parity_d;
    logic             ack_bit_q, ack_bit_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             done_q, done_d;
    logic             ack_ok_q, ack_ok_d;
    logic             error_q, error_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             timed_out;
    logic             abort;

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_cnt_q <= '0;
            shreg_q   <= '0;
            parity_q  <= 1'b0;
            ack_bit_q <= 1'b0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            done_q    <= 1'b0;
            ack_ok_q  <= 1'b0;
            error_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            parity_q  <= parity_d;
            ack_bit_q <= ack_bit_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            done_q    <= done_d;
            ack_ok_q  <= ack_ok_d;
            error_q   <= error_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    // Once the device owns the clock, any device edge resets the timeout;
    // a clock edge coincident with expiry wins over the timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d   = shreg_q;
        parity_d  = parity_q;
        ack_bit_d = ack_bit_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        ack_ok_d  = 1'b0;
        error_d   = 1'b0;
        abort     = 1'b0;
        timed_out = (cnt_q == TIMEOUT_LAST);

        case (state_q)
            IDLE: begin
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
                if (ready_q && bus.tx_valid) begin
                    shreg_d  = bus.tx_data;
                    parity_d = odd_parity(bus.tx_data);
                    cnt_d    = '0;
                    clk_oe_d = 1'b1;
                    state_d  = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                if (cnt_q == REQ_LAST) begin
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                    clk_oe_d  = 1'b0;
                    state_d   = SHIFT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            SHIFT: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q < 4'd8) begin
                        data_oe_d = ~shreg_q[bit_cnt_q[2:0]];
                    end else if (bit_cnt_q == 4'd8) begin
                        data_oe_d = ~parity_q;
                    end else begin
                        data_oe_d = 1'b0;
                        state_d   = ACK;
                    end
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    cnt_d     = '0;
                    ack_bit_d = ~data_level;
                    state_d   = WAIT_IDLE;
                end else if (data_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    done_d   = 1'b1;
                    ack_ok_d = ack_bit_q;
                    state_d  = IDLE;
                end else if (clk_fall || data_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (abort) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            error_d   = 1'b1;
            state_d   = IDLE;
        end

        // Ready is held off for the completion-pulse cycle so status settles first.
        ready_d = (state_d == IDLE) && !done_d && !error_d;
        busy_d  = !ready_d;
    end

    assign ps2_clk_oe   = clk_oe_q;
    assign ps2_data_oe  = data_oe_q;
    assign bus.tx_ready = ready_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.ack_ok   = ack_ok_q;
    assign bus.error    = error_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomised bench for ps2_host_tx: an open-drain PS/2 device model clocks frames
// out of the host while a scoreboard compares every done/error against a queue.
module tb_ps2_host_tx;
    localparam int INHIBIT = 200;
    localparam int TIMEOUT = 30000;
    localparam int HALF    = 80;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       ack;
        logic       is_err;
    } exp_t;

    typedef struct {
        logic [7:0] data;
        logic       parity;
        logic       stop;
    } cap_t;

    logic clk = 1'b0;
    logic res_n = 1'b0;
    logic ps2_clk_oe, ps2_data_oe;
    logic dev_clk_low = 1'b0;
    logic dev_data_low = 1'b0;
    logic ps2_clk_line, ps2_data_line;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int release_cyc = 0;
    int hold_cnt = 0;
    logic prev_clk_oe = 1'b0;
    logic ready_pending = 1'b0;

    exp_t exp_q[$];
    cap_t cap_q[$];

    ps2_host_tx_if bus();

    assign ps2_clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign ps2_data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .CLK_HZ         (2_000_000),
        .INHIBIT_CYCLES (INHIBIT),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk         (clk),
        .res_n       (res_n),
        .bus         (bus),
        .ps2_clk_in  (ps2_clk_line),
        .ps2_data_in (ps2_data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, actual, expected);
        end
    endtask

    function automatic logic ref_parity(input logic [7:0] b);
        return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Clock-hold length and release moment, observed from the host's clock enable.
    always @(negedge clk) begin
        if (!res_n) begin
            hold_cnt    = 0;
            prev_clk_oe = 1'b0;
        end else begin
            if (ps2_clk_oe) begin
                hold_cnt++;
            end else if (prev_clk_oe) begin
                release_cyc = cyc;
                check_output("clk_hold_cycles", hold_cnt, INHIBIT + 4);
                check_output("data_low_at_release", ps2_data_oe, 1);
                hold_cnt = 0;
            end
            prev_clk_oe = ps2_clk_oe;
        end
    end

    // Scoreboard: every done/error pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        cap_t c;
        if (!res_n) begin
            ready_pending = 1'b0;
        end else begin
            if (ready_pending) begin
                check_output("ready_after_pulse", bus.tx_ready, 1);
                ready_pending = 1'b0;
            end
            if (bus.done || bus.error) begin
                ready_pending = 1'b1;
                check_output("done_error_exclusive", bus.done & bus.error, 0);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_pulse: done=%0b error=%0b with nothing outstanding", bus.done, bus.error);
                end else begin
                    e = exp_q.pop_front();
                    check_output("error_flag", bus.error, e.is_err);
                    if (e.is_err) begin
                        check_output("timeout_latency", cyc - release_cyc, TIMEOUT);
                        check_output("oe_after_error", {ps2_clk_oe, ps2_data_oe}, 0);
                    end else begin
                        check_output("ack_ok", bus.ack_ok, e.ack);
                        if (cap_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("[TB] FAIL line_capture: got no frame on the line, wanted %0h", e.data);
                        end else begin
                            c = cap_q.pop_front();
                            check_output("line_data", c.data, e.data);
                            check_output("line_parity", c.parity, e.parity);
                            check_output("line_stop", c.stop, 1);
                        end
                    end
                end
            end
        end
    end

    // Device side of one frame; mode 0 acks, 1 omits ack, 2 never clocks.
    task automatic device_run(input int mode, input int abort_edge, input int inject_edge);
        logic [9:0] bits;
        int n;
        cap_t c;
        n = 0;
        while (!(ps2_clk_oe == 1'b0 && ps2_data_oe == 1'b1) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            check_output("request_to_send_seen", 0, 1);
            return;
        end
        if (mode == 2) return;
        repeat (HALF) @(negedge clk);
        for (int k = 1; k <= 11; k++) begin
            dev_clk_low = 1'b1;
            if (k == abort_edge) begin
                #2 res_n = 1'b0;
                #1;
                check_output("async_reset_clk_oe", ps2_clk_oe, 0);
                check_output("async_reset_data_oe", ps2_data_oe, 0);
                repeat (4) @(negedge clk);
                dev_clk_low  = 1'b0;
                dev_data_low = 1'b0;
                repeat (2) @(negedge clk);
                res_n = 1'b1;
                return;
            end
            if (k == inject_edge) begin
                bus.tx_data  = 8'hAA;
                bus.tx_valid = 1'b1;
                repeat (2) @(negedge clk);
                bus.tx_valid = 1'b0;
                repeat (HALF - 2) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            dev_clk_low = 1'b0;
            if (k <= 10) bits[k-1] = ps2_data_line;
            if (k == 10) begin
                c.data   = bits[7:0];
                c.parity = bits[8];
                c.stop   = bits[9];
                cap_q.push_back(c);
            end
            repeat (HALF / 2) @(negedge clk);
            if (k == 10 && mode == 0) dev_data_low = 1'b1;
            if (k == 11) dev_data_low = 1'b0;
            repeat (HALF / 2) @(negedge clk);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int mode, input int abort_edge, input int inject_edge);
        exp_t e;
        int n;
        n = 0;
        while (!bus.tx_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) check_output("ready_before_send", bus.tx_ready, 1);
        bus.tx_data  = b;
        bus.tx_valid = 1'b1;
        if (abort_edge == 0) begin
            e.data   = b;
            e.parity = ref_parity(b);
            e.ack    = (mode == 0);
            e.is_err = (mode == 2);
            exp_q.push_back(e);
        end
        @(negedge clk);
        check_output("busy_after_accept", bus.busy, 1);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
        device_run(mode, abort_edge, inject_edge);
        n = 0;
        while (bus.busy && n < TIMEOUT + 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= TIMEOUT + 2000) check_output("frame_finished", bus.busy, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        bus.tx_data  = 8'h00;
        bus.tx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_output("reset_clk_oe", ps2_clk_oe, 0);
        check_output("reset_data_oe", ps2_data_oe, 0);
        check_output("reset_ready", bus.tx_ready, 1);
        check_output("reset_busy", bus.busy, 0);
        check_output("reset_pulses", {bus.done, bus.ack_ok, bus.error}, 0);
        res_n = 1'b1;
        repeat (3) @(negedge clk);

        apply_stimulus(8'hF4, 0, 0, 0);
        apply_stimulus(8'hED, 0, 0, 0);
        apply_stimulus(8'h02, 0, 0, 0);
        apply_stimulus(8'hF4, 1, 0, 0);
        apply_stimulus(8'hFF, 2, 0, 0);
        check_output("ready_after_timeout", bus.tx_ready, 1);
        check_output("oe_idle_after_timeout", {ps2_clk_oe, ps2_data_oe}, 0);

        apply_stimulus(8'hF4, 0, 5, 0);
        repeat (20) @(negedge clk);
        check_output("no_pulse_after_reset", exp_q.size(), 0);
        apply_stimulus(8'h55, 0, 0, 0);

        apply_stimulus(8'hF4, 0, 0, 3);
        repeat (300) @(negedge clk);
        check_output("no_second_frame", bus.busy, 0);

        for (int i = 0; i < 6; i++) begin
            apply_stimulus(8'($urandom), int'($urandom_range(0, 1)), 0, 0);
        end

        repeat (10) @(negedge clk);
        check_output("scoreboard_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        bad++;
        $display("[TB] FAIL watchdog: simulation still running at time %0t", $time);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end
endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter that sends one command byte to a PS/2 keyboard or mouse, e.g. 0xF4 (mouse enable streaming) or 0xED plus LED byte (keyboard LEDs). It sits beside the existing PS/2 receive path on the same open-drain clock/data pair. It drives the lines through active-high pull-low enables and runs the full request-to-send, bit-shift and acknowledge sequence. While a frame is in flight, the receive path ignores the lines via `busy`.

## Interface
Parameters:
- `CLK_HZ`, 2000000, system clock frequency.
- `INHIBIT_CYCLES`, 200, clock-low inhibit time (100 µs at 2 MHz).
- `TIMEOUT_CYCLES`, 30000, maximum wait for a device clock edge (15 ms).

Ports:
- `clk` in 1: system clock; all logic rises on it.
- `res_n` in 1: asynchronous, active-low reset.
- `tx_data` in 8: byte to send.
- `tx_valid` in 1: request; accepted when `tx_valid && tx_ready`.
- `tx_ready` out 1: high only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at frame completion.
- `ack_ok` out 1: valid with `done`; 1 means the device acknowledged.
- `error` out 1: one-cycle pulse on timeout.
- `ps2_clk_in` in 1: raw line level (asynchronous).
- `ps2_data_in` in 1: raw line level (asynchronous).
- `ps2_clk_oe` out 1: 1 pulls the clock line low.
- `ps2_data_oe` out 1: 1 pulls the data line low.

## Operation
- Inputs pass through a 2-FF synchroniser. A falling edge is synced-previous=1 and synced-current=0.
- Odd parity bit = `~^tx_data`, computed from the byte latched at accept.
- States and transitions:
  - IDLE: both oe=0. On accept, latch byte, compute parity, go to INHIBIT.
  - INHIBIT: `ps2_clk_oe`=1 for INHIBIT_CYCLES, then REQ.
  - REQ: `ps2_clk_oe`=1 and `ps2_data_oe`=1 for 4 cycles, then release clock (`ps2_clk_oe`=0, data held low) and go to SHIFT. The bit counter and timeout counter clear here.
  - SHIFT: counter counts falling edges of the device clock.
    - Edges 1–8: `ps2_data_oe` = ~bit[edge-1], LSB first.
    - Edge 9: `ps2_data_oe` = ~parity.
    - Edge 10: `ps2_data_oe`=0 (stop bit, line released). Go to ACK.
  - ACK: at the next falling edge, sample synced data; `ack_ok` = ~data. Go to WAIT_IDLE.
  - WAIT_IDLE: wait until synced clock=1 and data=1. Then pulse `done` with `ack_ok`, go to IDLE.
- Timeout:
  - The timeout counter runs in SHIFT, ACK and WAIT_IDLE, and clears on every device falling edge.
  - On reaching TIMEOUT_CYCLES: both oe=0, pulse `error`, no `done`, go to IDLE.
- `tx_valid` outside IDLE is ignored; there is no queueing.

## Timing
- Reset values: `ps2_clk_oe`=0, `ps2_data_oe`=0, `tx_ready`=1, `busy`=0, `done`=0, `ack_ok`=0, `error`=0, state=IDLE.
- All outputs are registered.
- If accept occurs in cycle N, then `ps2_clk_oe`=1 and `busy`=1 from cycle N+1.
- Clock release occurs INHIBIT_CYCLES+4 cycles after N+1.
- Data output changes 3 cycles after the raw falling edge: 2 sync stages plus 1 register. Device clock half-periods are 30–50 µs (≥60 cycles), so this is well within the allowed window.
- Reset asserted mid-frame: both oe drop to 0 asynchronously, no `done` or `error` pulse.
- A falling edge coincident with timeout expiry counts as an edge; the timeout does not fire.
- `tx_ready` returns high the cycle after `done` or `error`.
- `done` and `error` are never asserted together.

## Structure
- Shared package `ps2_pkg` holds:
  - the state enum (IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE);
  - the 4-cycle REQ hold constant;
  - PS/2 command constants (0xF4 enable reporting, 0xED set LEDs, 0xFF reset).
- One sub-module, `ps2_line_sync`: 2-FF synchroniser plus falling-edge detect, instantiated once per line. The existing receive path reuses it.

## Test plan
- Send 0xF4 with a device model (40 µs clock half-period, ACK at edge 11):
  - clock is held low ≥200 cycles;
  - data bits sampled on rising edges = 0,0,1,0,1,1,1,1;
  - parity=0, stop=1;
  - `done`=1 with `ack_ok`=1.
- Send 0xED: bits 1,0,1,1,0,1,1,1 and parity=1. Then send 0x02: parity=0. Both end with `ack_ok`=1.
- Device never clocks: `error` pulses exactly TIMEOUT_CYCLES after clock release, both oe=0, `tx_ready`=1.
- Device omits ACK (data high at edge 11): `done`=1 with `ack_ok`=0, no `error`.
- Assert `res_n` low during edge 5: oe outputs are 0 within the same cycle (asynchronous), no pulses. A new 0x55 sent after reset completes correctly.
- Pulse `tx_valid` with 0xAA during SHIFT of 0xF4: it is ignored, exactly one frame goes out, and 0xAA bits never appear on the line.
